// File: rtl/clock_divider_multi.sv
// Multi-channel 50%-duty clock divider with per-channel tick strobes and
// glitch-free run-time divisor updates that take effect only at half-period boundaries.

module clock_divider_lane #(
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(25_000_000)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] d_m1;
  logic             term;
  logic             halt;
  logic             apply;

  // A zero divisor behaves as one, so the terminal count is zero in both cases.
  assign d_m1  = (act_div == '0) ? '0 : act_div - CNT_W'(1);
  assign term  = (cnt == d_m1);
  assign halt  = sync || !en;
  assign apply = pending && (halt || term);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      pending  <= 1'b0;
      act_div  <= DEFAULT_DIV;
      pend_div <= DEFAULT_DIV;
    end else begin
      if (halt) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (term) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= 1'b1;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        tick    <= 1'b0;
      end
      if (apply) begin
        act_div <= pend_div;
        pending <= 1'b0;
      end
      // A write on the apply edge still lands and keeps the channel pending.
      if (wr) begin
        pend_div <= wr_div;
        pending  <= 1'b1;
      end
    end
  end

endmodule

module clock_divider_multi #(
  parameter int               NUM_CH      = 4,
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(25_000_000),
  localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] wr_sel;

  // Out-of-range channel numbers match no lane, so such writes fall away.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

    clock_divider_lane #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_lane (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .en      (en[i]),
      .sync    (sync),
      .wr      (wr_sel[i]),
      .wr_div  (wr_div),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule
